i2c_burst_reader: RTL

Parametrised I2C master read engine that generalises the single-shot read block. Supports an optional register-address write phase followed by a repeated START, then a programmable-length burst read of 1..MAX_BYTES bytes. Provides address/register NACK detection and a configurable bit-rate divider. Sits between sensor/EEPROM control FSMs and the open-drain SDA/SCL pad logic, which ties low when an output is 0 and releases when it is 1.

---
 rtl/i2c_pkg.sv | 26 ++
 rtl/i2c_phase_gen.sv | 41 ++++
 rtl/i2c_burst_reader.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared types for the I2C burst reader: FSM states, quarter-bit phases and R/W bit values.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        START,
        ADDR,
        REG,
        RSTART,
        READ,
        MACK,
        STOP,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        Q0,
        Q1,
        Q2,
        Q3
    } qtr_t;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_phase_gen.sv
// Bit-rate divider and quarter-phase counter for the I2C burst reader.
// A tick fires every QTR_DIV cycles while enabled; i_hold freezes both counters.
module i2c_phase_gen
    import i2c_pkg::*;
#(
    parameter int unsigned QTR_DIV = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_hold,
    output logic o_tick,
    output qtr_t o_qtr
);

    localparam int unsigned       DIV_W   = (QTR_DIV > 1) ? $clog2(QTR_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_MAX = DIV_W'(QTR_DIV - 1);

    logic [DIV_W-1:0] r_div;
    qtr_t             r_qtr;
    logic             w_last;

    assign w_last = (r_div == DIV_MAX);
    assign o_tick = i_en && !i_hold && w_last;
    assign o_qtr  = r_qtr;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || !i_en) begin
            r_div <= '0;
            r_qtr <= Q0;
        end else if (!i_hold) begin
            if (w_last) begin
                r_div <= '0;
                r_qtr <= qtr_t'(r_qtr + 2'd1);
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_burst_reader.sv
// I2C master burst read engine: optional register-pointer write, repeated START, 1..MAX_BYTES read.
// Define I2C_CLK_STRETCH_EN to let a slave stretch SCL after each release.
module i2c_burst_reader
    import i2c_pkg::*;
#(
    parameter int unsigned MAX_BYTES = 4,
    parameter int unsigned QTR_DIV   = 1,
    parameter int unsigned CNT_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic                   PT_CK,
    input  logic                   RESET_N,
    input  logic                   GO,
    input  logic [6:0]             SLAVE_ADDR,
    input  logic                   USE_REG,
    input  logic [7:0]             REG_ADDR,
    input  logic [CNT_W-1:0]       NUM_BYTES,
    input  logic                   SDAI,
    input  logic                   SCLI,
    output logic                   SDAO,
    output logic                   SCLO,
    output logic                   BUSY,
    output logic                   END_OK,
    output logic                   ACK_ERR,
    output logic [8*MAX_BYTES-1:0] DATA
);

    localparam int unsigned DW = 8 * MAX_BYTES;

    state_t           r_state, w_state_nxt;
    logic             r_go_d;
    logic [6:0]       r_addr;
    logic             r_use_reg;
    logic [7:0]       r_reg;
    logic [CNT_W-1:0] r_num, w_num_clamp;
    logic [3:0]       r_bit, w_bit_nxt;
    logic [CNT_W-1:0] r_byte, w_byte_nxt;
    logic             r_rd_phase, w_rd_phase_nxt;
    logic             r_sdao, w_sdao_nxt;
    logic             r_sclo, w_sclo_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_end_ok, w_end_ok_nxt;
    logic             r_ack_err, w_ack_err_nxt;
    logic [DW-1:0]    r_data, w_data_nxt;
    logic             w_accept, w_tick, w_hold, w_en, w_rw, w_last_byte;
    logic [7:0]       w_tx;
    qtr_t             w_qtr;

    assign w_en        = (r_state != IDLE) && (r_state != DONE);
    assign w_num_clamp = (NUM_BYTES > CNT_W'(MAX_BYTES)) ? CNT_W'(MAX_BYTES) : NUM_BYTES;
    assign w_rw        = (r_use_reg && !r_rd_phase) ? RW_WRITE : RW_READ;
    assign w_tx        = (r_state == REG) ? r_reg : {r_addr, w_rw};
    assign w_last_byte = (r_byte == r_num - 1'b1);

`ifdef I2C_CLK_STRETCH_EN
    assign w_hold = r_sclo && !SCLI;
`else
    // Fixed timing: SCLI has no effect on the phase counter.
    assign w_hold = 1'b0 & SCLI;
`endif

    i2c_phase_gen #(.QTR_DIV(QTR_DIV)) u_phase (
        .i_clk   (PT_CK),
        .i_rst_n (RESET_N),
        .i_en    (w_en),
        .i_hold  (w_hold),
        .o_tick  (w_tick),
        .o_qtr   (w_qtr)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_sdao_nxt     = r_sdao;
        w_sclo_nxt     = r_sclo;
        w_busy_nxt     = r_busy;
        w_end_ok_nxt   = 1'b0;
        w_ack_err_nxt  = r_ack_err;
        w_data_nxt     = r_data;
        w_bit_nxt      = r_bit;
        w_byte_nxt     = r_byte;
        w_rd_phase_nxt = r_rd_phase;
        w_accept       = 1'b0;
        if (r_state == IDLE) begin
            if (GO && !r_go_d) begin
                w_accept       = 1'b1;
                w_busy_nxt     = 1'b1;
                w_ack_err_nxt  = 1'b0;
                w_data_nxt     = '0;
                w_bit_nxt      = '0;
                w_byte_nxt     = '0;
                w_rd_phase_nxt = 1'b0;
                w_state_nxt    = (w_num_clamp == '0) ? DONE : START;
            end
        end else if (r_state == DONE) begin
            w_end_ok_nxt = 1'b1;
            w_busy_nxt   = 1'b0;
            w_state_nxt  = IDLE;
        end else if (w_tick) begin
            case (r_state)
                START: case (w_qtr)
                    Q1:      w_sdao_nxt = 1'b0;
                    Q3:      begin w_sclo_nxt = 1'b0; w_state_nxt = ADDR; end
                    default: ;
                endcase
                // Address and register bytes share the 8-bit + slave-ACK slot sequence.
                ADDR, REG: case (w_qtr)
                    Q0: begin
                        w_sclo_nxt = 1'b0;
                        w_sdao_nxt = (r_bit == 4'd8) ? 1'b1 : w_tx[3'd7 - r_bit[2:0]];
                    end
                    Q1: w_sclo_nxt = 1'b1;
                    Q2: if (r_bit == 4'd8 && SDAI) w_ack_err_nxt = 1'b1;
                    Q3: begin
                        w_sclo_nxt = 1'b0;
                        if (r_bit != 4'd8) begin
                            w_bit_nxt = r_bit + 4'd1;
                        end else begin
                            w_bit_nxt = '0;
                            if (r_ack_err) begin
                                w_state_nxt = STOP;
                            end else if (r_state == REG) begin
                                w_state_nxt    = RSTART;
                                w_rd_phase_nxt = 1'b1;
                            end else begin
                                w_state_nxt = (w_rw == RW_WRITE) ? REG : READ;
                            end
                        end
                    end
                endcase
                RSTART: case (w_qtr)
                    Q0: w_sdao_nxt = 1'b1;
                    Q1: w_sclo_nxt = 1'b1;
                    Q2: w_sdao_nxt = 1'b0;
                    Q3: begin w_sclo_nxt = 1'b0; w_state_nxt = ADDR; end
                endcase
                READ: case (w_qtr)
                    Q0: begin w_sclo_nxt = 1'b0; w_sdao_nxt = 1'b1; end
                    Q1: w_sclo_nxt = 1'b1;
                    Q2: w_data_nxt = {r_data[DW-2:0], SDAI};
                    Q3: begin
                        w_sclo_nxt = 1'b0;
                        if (r_bit == 4'd7) begin
                            w_bit_nxt   = '0;
                            w_state_nxt = MACK;
                        end else begin
                            w_bit_nxt = r_bit + 4'd1;
                        end
                    end
                endcase
                MACK: case (w_qtr)
                    Q0: begin w_sclo_nxt = 1'b0; w_sdao_nxt = w_last_byte; end
                    Q1: w_sclo_nxt = 1'b1;
                    Q3: begin
                        w_sclo_nxt = 1'b0;
                        if (w_last_byte) begin
                            w_state_nxt = STOP;
                        end else begin
                            w_byte_nxt  = r_byte + 1'b1;
                            w_state_nxt = READ;
                        end
                    end
                    default: ;
                endcase
                STOP: case (w_qtr)
                    Q0: begin w_sclo_nxt = 1'b0; w_sdao_nxt = 1'b0; end
                    Q1: w_sclo_nxt = 1'b1;
                    Q2: w_sdao_nxt = 1'b1;
                    Q3: w_state_nxt = DONE;
                endcase
                default: ;
            endcase
        end
    end

    always_ff @(posedge PT_CK) begin
        if (!RESET_N) begin
            r_state    <= IDLE;
            r_go_d     <= 1'b0;
            r_addr     <= '0;
            r_use_reg  <= 1'b0;
            r_reg      <= '0;
            r_num      <= '0;
            r_bit      <= '0;
            r_byte     <= '0;
            r_rd_phase <= 1'b0;
            r_sdao     <= 1'b1;
            r_sclo     <= 1'b1;
            r_busy     <= 1'b0;
            r_end_ok   <= 1'b0;
            r_ack_err  <= 1'b0;
            r_data     <= '0;
        end else begin
            r_go_d     <= GO;
            r_state    <= w_state_nxt;
            r_bit      <= w_bit_nxt;
            r_byte     <= w_byte_nxt;
            r_rd_phase <= w_rd_phase_nxt;
            r_sdao     <= w_sdao_nxt;
            r_sclo     <= w_sclo_nxt;
            r_busy     <= w_busy_nxt;
            r_end_ok   <= w_end_ok_nxt;
            r_ack_err  <= w_ack_err_nxt;
            r_data     <= w_data_nxt;
            if (w_accept) begin
                r_addr    <= SLAVE_ADDR;
                r_use_reg <= USE_REG;
                r_reg     <= REG_ADDR;
                r_num     <= w_num_clamp;
            end
        end
    end

    assign SDAO    = r_sdao;
    assign SCLO    = r_sclo;
    assign BUSY    = r_busy;
    assign END_OK  = r_end_ok;
    assign ACK_ERR = r_ack_err;
    assign DATA    = r_data;

endmodule
